// File: rtl/canvas_scanout_if.sv
// Canvas read port between the scanout engine and the canvas bitmap memory.
//   readX      : canvas read column (0..H_ACTIVE-1), driven by the scanout
//   readY      : canvas read row (0..V_ACTIVE-1), driven by the scanout
//   pixelState : cell state for readX/readY, returned by the memory
// Modports: master = scanout side, slave = canvas memory side.
interface canvas_scanout_if;
  logic [9:0] readX;
  logic [8:0] readY;
  logic       pixelState;

  modport master (
    output readX,
    output readY,
    input  pixelState
  );

  modport slave (
    input  readX,
    input  readY,
    output pixelState
  );
endinterface

// File: rtl/canvas_scanout.sv
// VGA scanout for the canvas bitmap. Generates pixel-rate timing from the system clock
// through a divider, fetches each visible cell from the canvas and renders it as
// cursor / alive / grid / dead colour, with syncs pipelined in step with the RGB stream.
// Ports:
//   clk, rst             : system clock, synchronous active-high reset
//   canvas               : canvas read port (readX/readY out, pixelState in)
//   cursor_x/y, cursor_en: cursor position in screen pixels and overlay enable
//   vga_r/g/b            : 4-bit colour channels
//   hsync, vsync         : sync outputs, active level SYNC_POL
//   pix_tick             : one-clk strobe per pixel period
//   frame_start          : one-clk pulse when the counters wrap to (0,0)
module canvas_scanout #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter logic        SYNC_POL   = 1'b0,
  parameter logic [11:0] ALIVE_RGB  = 12'hFFF,
  parameter logic [11:0] DEAD_RGB   = 12'h000,
  parameter logic [11:0] GRID_RGB   = 12'h222,
  parameter logic [11:0] CURSOR_RGB = 12'hF00,
  parameter bit          GRID_EN    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  canvas_scanout_if.master        canvas,
  input  logic [9:0]              cursor_x,
  input  logic [8:0]              cursor_y,
  input  logic                    cursor_en,
  output logic [3:0]              vga_r,
  output logic [3:0]              vga_g,
  output logic [3:0]              vga_b,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    pix_tick,
  output logic                    frame_start
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast    = DivW'(CLK_DIV - 1);
  localparam logic [9:0]      HLast      = 10'(HTotal - 1);
  localparam logic [8:0]      VLast      = 9'(VTotal - 1);
  localparam logic [9:0]      HActEnd    = 10'(H_ACTIVE);
  localparam logic [8:0]      VActEnd    = 9'(V_ACTIVE);
  localparam logic [9:0]      HSyncFirst = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]      HSyncLast  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [8:0]      VSyncFirst = 9'(V_ACTIVE + V_FP);
  localparam logic [8:0]      VSyncLast  = 9'(V_ACTIVE + V_FP + V_SYNC - 1);

  // The colour stage samples pixelState one full pixel period after the address moves.
  if (CLK_DIV < READ_LAT + 1) begin : g_clk_div_check
    $error("canvas_scanout: CLK_DIV must be at least READ_LAT+1");
  end

  // Divider and raster counters
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            pix_tick_q;
  logic [9:0]      h_cnt_q, h_cnt_d;
  logic [8:0]      v_cnt_q, v_cnt_d;
  logic            frame_start_q;

  // Cursor latch, refreshed only at frame wrap
  logic [9:0]      cur_x_q;
  logic [8:0]      cur_y_q;
  logic            cur_en_q;

  // Stage 0: address plus the attributes carried alongside it
  logic [9:0]      s0_x_q;
  logic [8:0]      s0_y_q;
  logic            s0_active_q, s0_hs_q, s0_vs_q;

  // Stage 1: pin-facing registers
  logic [11:0]     rgb_q;
  logic            hs_q, vs_q;

  logic            h_wrap, v_wrap, frame_wrap;
  logic            active, hs_now, vs_now;
  logic            cursor_ok, cursor_hit, on_grid;
  logic [11:0]     rgb_d;

  always_comb begin
    div_cnt_d  = (div_cnt_q == DivLast) ? '0 : div_cnt_q + DivW'(1);

    h_wrap     = (h_cnt_q == HLast);
    v_wrap     = (v_cnt_q == VLast);
    frame_wrap = pix_tick_q & h_wrap & v_wrap;

    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_tick_q) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
      if (h_wrap) begin
        v_cnt_d = v_wrap ? '0 : v_cnt_q + 9'd1;
      end
    end

    active = (h_cnt_q < HActEnd) && (v_cnt_q < VActEnd);
    hs_now = ((h_cnt_q >= HSyncFirst) && (h_cnt_q <= HSyncLast)) ? SYNC_POL : ~SYNC_POL;
    vs_now = ((v_cnt_q >= VSyncFirst) && (v_cnt_q <= VSyncLast)) ? SYNC_POL : ~SYNC_POL;

    // An off-screen cursor is latched as disabled so it can never wrap onto the canvas.
    cursor_ok  = (cursor_x < HActEnd) && (cursor_y < VActEnd);
    cursor_hit = cur_en_q && (s0_x_q[9:1] == cur_x_q[9:1]) && (s0_y_q[8:1] == cur_y_q[8:1]);
    on_grid    = GRID_EN && ((s0_x_q[2:0] == 3'd0) || (s0_y_q[2:0] == 3'd0));

    // Blanking is tested first so pixelState is never looked at outside the canvas.
    rgb_d = DEAD_RGB;
    if (!s0_active_q) begin
      rgb_d = 12'h000;
    end else if (cursor_hit) begin
      rgb_d = CURSOR_RGB;
    end else if (canvas.pixelState) begin
      rgb_d = ALIVE_RGB;
    end else if (on_grid) begin
      rgb_d = GRID_RGB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      pix_tick_q    <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_start_q <= 1'b0;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      cur_en_q      <= 1'b0;
      s0_x_q        <= '0;
      s0_y_q        <= '0;
      s0_active_q   <= 1'b0;
      s0_hs_q       <= ~SYNC_POL;
      s0_vs_q       <= ~SYNC_POL;
      rgb_q         <= '0;
      hs_q          <= ~SYNC_POL;
      vs_q          <= ~SYNC_POL;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_tick_q    <= (div_cnt_d == DivLast);
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_wrap;
      if (frame_wrap) begin
        cur_x_q  <= cursor_x;
        cur_y_q  <= cursor_y;
        cur_en_q <= cursor_en & cursor_ok;
      end
      if (pix_tick_q) begin
        s0_x_q      <= active ? h_cnt_q : '0;
        s0_y_q      <= active ? v_cnt_q : '0;
        s0_active_q <= active;
        s0_hs_q     <= hs_now;
        s0_vs_q     <= vs_now;
        rgb_q       <= rgb_d;
        hs_q        <= s0_hs_q;
        vs_q        <= s0_vs_q;
      end
    end
  end

  assign canvas.readX = s0_x_q;
  assign canvas.readY = s0_y_q;
  assign vga_r        = rgb_q[11:8];
  assign vga_g        = rgb_q[7:4];
  assign vga_b        = rgb_q[3:0];
  assign hsync        = hs_q;
  assign vsync        = vs_q;
  assign pix_tick     = pix_tick_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_canvas_scanout.sv
// Scoreboard bench for canvas_scanout on a shrunken raster (24x18 pixel periods per frame)
// so many frames fit in a short run. A producer pushes the expected pin state for every
// pixel tick from a raster-index model; a monitor pops and compares after each tick.
module tb_canvas_scanout;

  localparam int CD = 4;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 12, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int F  = HT * VT;
  localparam logic SP = 1'b0;
  localparam logic [11:0] ALIVE = 12'hFFF, DEAD = 12'h000, GRID = 12'h222, CURS = 12'hF00;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [9:0]  rx;
    logic [8:0]  ry;
  } exp_t;

  logic       clk, rst;
  logic [9:0] cursor_x;
  logic [8:0] cursor_y;
  logic       cursor_en;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       hsync, vsync, pix_tick, frame_start;

  canvas_scanout_if bus ();

  canvas_scanout #(
    .CLK_DIV (CD), .READ_LAT (1),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(SP), .ALIVE_RGB(ALIVE), .DEAD_RGB(DEAD), .GRID_RGB(GRID),
    .CURSOR_RGB(CURS), .GRID_EN(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .canvas     (bus.master),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .cursor_en  (cursor_en),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .hsync      (hsync),
    .vsync      (vsync),
    .pix_tick   (pix_tick),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_pass = 0, n_checks = 0;
  int   tick_checks = 0;
  bit   canvas_bits [HA*VA];
  bit   blank_now = 1'b1;
  exp_t exp_q [$];

  // Model cursor latch
  bit   m_en = 1'b0;
  int   m_cx = 0, m_cy = 0;
  int   k_prod = 0;

  // Canvas memory, one clock of read latency; garbage stands in for X while blanking.
  always @(posedge clk) begin
    if (blank_now) bus.pixelState <= 1'($urandom);
    else if (bus.readX < HA && bus.readY < VA)
      bus.pixelState <= canvas_bits[int'(bus.readY) * HA + int'(bus.readX)];
    else bus.pixelState <= 1'($urandom);
  end

  // Expected pins after the k-th tick: RGB/syncs show raster index k-2, address shows k-1.
  function automatic exp_t expect_for(int k);
    exp_t e;
    int p, h, v;
    e.rgb = 12'h000; e.hs = ~SP; e.vs = ~SP; e.fs = 1'b0; e.rx = '0; e.ry = '0;
    if (k >= 2) begin
      p = k - 2; h = p % HT; v = (p / HT) % VT;
      if (h < HA && v < VA) begin
        if (m_en && h / 2 == m_cx / 2 && v / 2 == m_cy / 2) e.rgb = CURS;
        else if (canvas_bits[v * HA + h])                   e.rgb = ALIVE;
        else if (h % 8 == 0 || v % 8 == 0)                   e.rgb = GRID;
        else                                                 e.rgb = DEAD;
      end
      if (h >= HA + HF && h < HA + HF + HS) e.hs = SP;
      if (v >= VA + VF && v < VA + VF + VS) e.vs = SP;
    end
    p = k - 1; h = p % HT; v = (p / HT) % VT;
    if (h < HA && v < VA) begin
      e.rx = 10'(h);
      e.ry = 9'(v);
    end
    e.fs = (p % F) == F - 1;
    return e;
  endfunction

  // Producer: a tick is about to fire at the next posedge.
  always @(negedge clk) begin
    int p, h, v;
    if (rst) begin
      k_prod = 0; exp_q.delete(); m_en = 1'b0; m_cx = 0; m_cy = 0; blank_now = 1'b1;
    end else if (pix_tick) begin
      k_prod++;
      exp_q.push_back(expect_for(k_prod));
      p = k_prod - 1; h = p % HT; v = (p / HT) % VT;
      if (p % F == F - 1) begin
        m_en = cursor_en && cursor_x < HA && cursor_y < VA;
        m_cx = int'(cursor_x);
        m_cy = int'(cursor_y);
      end
      blank_now = !(h < HA && v < VA);
    end
  end

  // Monitor: compares pins one negedge after each tick, and the tick spacing.
  bit tick_seen = 1'b0;
  int clk_since = 0, ticks_mon = 0;
  always @(negedge clk) begin
    exp_t e, a;
    if (rst) begin
      tick_seen = 1'b0; clk_since = 0; ticks_mon = 0;
    end else begin
      if (tick_seen) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL scoreboard_empty: got tick with no expectation, want queued entry");
        end else begin
          e = exp_q.pop_front();
          a = '{rgb: {vga_r, vga_g, vga_b}, hs: hsync, vs: vsync, fs: frame_start,
                rx: bus.readX, ry: bus.readY};
          tick_checks++;
          if (a !== e)
            $display("FAIL pixel_tick %0d: got rgb=%h hs=%b vs=%b fs=%b rd=(%0d,%0d) want rgb=%h hs=%b vs=%b fs=%b rd=(%0d,%0d)",
                     ticks_mon, a.rgb, a.hs, a.vs, a.fs, a.rx, a.ry,
                     e.rgb, e.hs, e.vs, e.fs, e.rx, e.ry);
          else n_pass++;
        end
      end else if (frame_start !== 1'b0) begin
        n_checks++;
        $display("FAIL frame_start_stray: got %b, want 0 away from a tick", frame_start);
      end
      clk_since++;
      if (pix_tick) begin
        if (ticks_mon > 0) begin
          n_checks++;
          if (clk_since != CD)
            $display("FAIL tick_period: got %0d clk, want %0d", clk_since, CD);
          else n_pass++;
        end
        ticks_mon++;
        clk_since = 0;
      end
      tick_seen = pix_tick;
    end
  end

  task automatic check_reset(input string name);
    logic [35:0] got, want;
    got  = {vga_r, vga_g, vga_b, hsync, vsync, pix_tick, frame_start, bus.readX, bus.readY};
    want = {12'h000, ~SP, ~SP, 1'b0, 1'b0, 10'd0, 9'd0};
    n_checks++;
    if (got !== want) $display("FAIL %s: got %h, want %h", name, got, want);
    else n_pass++;
  endtask

  task automatic fill_canvas();
    for (int i = 0; i < HA * VA; i++) canvas_bits[i] = ($urandom_range(0, 3) == 0);
  endtask

  task automatic run_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cursor(input int x, input int y, input bit en);
    cursor_x = 10'(x); cursor_y = 9'(y); cursor_en = en;
  endtask

  initial begin
    rst = 1'b1;
    set_cursor(0, 0, 1'b0);
    fill_canvas();
    run_clks(3);
    check_reset("reset_values");
    rst = 1'b0;

    // Plain rendering, grid overlay, syncs and frame_start over two frames.
    run_clks(2 * F * CD);

    // Cursor applied mid-frame must wait for the next frame.
    run_clks($urandom_range(F * CD / 4, 3 * F * CD / 4));
    set_cursor($urandom_range(0, HA - 1), $urandom_range(0, VA - 1), 1'b1);
    run_clks(2 * F * CD);

    // Off-screen cursor draws nothing.
    set_cursor(HA + $urandom_range(0, 20), $urandom_range(0, VA - 1), 1'b1);
    run_clks(F * CD);
    set_cursor($urandom_range(0, HA - 1), VA + $urandom_range(0, 20), 1'b1);
    run_clks(F * CD);

    // Mid-frame reset: one clk, then timing restarts from (0,0).
    run_clks($urandom_range(F * CD / 4, 3 * F * CD / 4));
    rst = 1'b1;
    fill_canvas();
    run_clks(1);
    check_reset("midframe_reset_values");
    rst = 1'b0;
    set_cursor($urandom_range(0, HA - 1), $urandom_range(0, VA - 1), 1'b1);
    run_clks(2 * F * CD);

    // Cursor moves at random points within frames.
    for (int i = 0; i < 12; i++) begin
      set_cursor($urandom_range(0, HA + 3), $urandom_range(0, VA + 3),
                 $urandom_range(0, 3) != 0);
      run_clks(F * CD / 4);
    end
    run_clks(4 * CD);

    n_checks++;
    if (tick_checks < 10 * F)
      $display("FAIL tick_coverage: got %0d pixel checks, want at least %0d", tick_checks, 10 * F);
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
